// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with expiry pulse and low-count flag.
// Define COUNTDOWN_AUTORELOAD_EN to restart from the last loaded value after each expiry.
module countdown_timer #(
  parameter int SIZE   = 8,
  parameter int THRESH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_valid,
  input  logic [SIZE-1:0] load_val,
  output logic            load_ready,
  input  logic            pause,
  input  logic            abort,
  output logic [SIZE-1:0] out,
  output logic            busy,
  output logic            low,
  output logic            expired
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [SIZE-1:0] TH = SIZE'(THRESH);
  logic [1:0]      state_q, state_d;
  logic [SIZE-1:0] out_q, out_d;
`ifdef COUNTDOWN_AUTORELOAD_EN
  logic [SIZE-1:0] reload_q, reload_d;
`endif
  assign load_ready = state_q == IDLE;
  assign busy       = state_q == RUN;
  assign low        = busy && out_q <= TH;
  assign expired    = state_q == DONE;
  assign out        = out_q;
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
`ifdef COUNTDOWN_AUTORELOAD_EN
    reload_d = reload_q;
`endif
    if (state_q == IDLE) begin
      if (load_valid) begin
        out_d   = load_val;
        state_d = (load_val != '0) ? RUN : DONE;
`ifdef COUNTDOWN_AUTORELOAD_EN
        reload_d = load_val;
`endif
      end
    end else if (state_q == RUN) begin
      if (abort) state_d = IDLE;
      else if (!pause) begin
        out_d   = out_q - SIZE'(1);
        state_d = (out_q == SIZE'(1)) ? DONE : RUN;
      end
    end else if (state_q == DONE) begin
`ifdef COUNTDOWN_AUTORELOAD_EN
      if (abort) state_d = IDLE;
      else if (reload_q != '0) begin
        state_d = RUN;
        out_d   = reload_q;
      end
`else
      state_d = IDLE;
`endif
    end else state_d = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      out_q   <= '0;
`ifdef COUNTDOWN_AUTORELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
`ifdef COUNTDOWN_AUTORELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed vector table plus hand sequences for reset, and auto-reload when enabled.
module tb_countdown_timer;
  logic       clk = 0;
  logic       rst_n = 0;
  logic       load_valid = 0;
  logic [7:0] load_val = 0;
  logic       load_ready;
  logic       pause = 0;
  logic       abort = 0;
  logic [7:0] out;
  logic       busy;
  logic       low;
  logic       expired;
  int total = 0;
  int bad = 0;
  typedef struct {
    logic       lv;
    logic [7:0] val;
    logic       p;
    logic       a;
    logic [7:0] eo;
    logic       er;
    logic       eb;
    logic       el;
    logic       ee;
  } vec_t;
  vec_t tbl[$];
  countdown_timer #(.SIZE(8), .THRESH(8)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_val(load_val),
    .load_ready(load_ready), .pause(pause), .abort(abort), .out(out),
    .busy(busy), .low(low), .expired(expired)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic add(input logic lv, input logic [7:0] val, input logic p, input logic a,
                     input logic [7:0] eo, input logic er, input logic eb, input logic el, input logic ee);
    vec_t v;
    v.lv = lv; v.val = val; v.p = p; v.a = a;
    v.eo = eo; v.er = er; v.eb = eb; v.el = el; v.ee = ee;
    tbl.push_back(v);
  endtask
  task automatic idle_in();
    @(negedge clk);
    load_valid = 0; load_val = 0; pause = 0; abort = 0;
  endtask
  initial begin
    // Basic count of 10; low from 8 down; abort in DONE returns to IDLE in both builds
    add(1, 10, 0, 0, 10, 0, 1, 0, 0);
    for (int k = 9; k >= 1; k--) add(0, 0, 0, 0, 8'(k), 0, 1, k <= 8, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 1, 0, 1, 0, 0, 0);
    // Pause for three cycles at out=3
    add(1, 5, 0, 0, 5, 0, 1, 1, 0);
    add(0, 0, 0, 0, 4, 0, 1, 1, 0);
    add(0, 0, 0, 0, 3, 0, 1, 1, 0);
    for (int k = 0; k < 3; k++) add(0, 0, 1, 0, 3, 0, 1, 1, 0);
    add(0, 0, 0, 0, 2, 0, 1, 1, 0);
    add(0, 0, 0, 0, 1, 0, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 1, 0, 1, 0, 0, 0);
    // Load 0: straight to DONE, busy never set
    add(1, 0, 0, 0, 0, 0, 0, 0, 1);
`ifdef COUNTDOWN_AUTORELOAD_EN
    add(0, 0, 0, 0, 0, 0, 0, 0, 1);
`else
    add(0, 0, 0, 0, 0, 1, 0, 0, 0);
`endif
    add(0, 0, 0, 1, 0, 1, 0, 0, 0);
    // Load 4, abort (with pause) at out=1: out holds, no expiry
    add(1, 4, 0, 0, 4, 0, 1, 1, 0);
    add(0, 0, 0, 0, 3, 0, 1, 1, 0);
    add(0, 0, 0, 0, 2, 0, 1, 1, 0);
    add(0, 0, 0, 0, 1, 0, 1, 1, 0);
    add(0, 0, 1, 1, 1, 1, 0, 0, 0);
    add(0, 0, 0, 0, 1, 1, 0, 0, 0);
    // load_valid with 7 held during RUN/DONE: ignored, then accepted once in IDLE
    add(1, 3, 0, 0, 3, 0, 1, 1, 0);
    add(1, 7, 0, 0, 2, 0, 1, 1, 0);
    add(1, 7, 0, 0, 1, 0, 1, 1, 0);
    add(1, 7, 0, 0, 0, 0, 0, 0, 1);
    add(1, 7, 0, 1, 0, 1, 0, 0, 0);
    add(1, 7, 0, 0, 7, 0, 1, 1, 0);
    add(0, 0, 0, 0, 6, 0, 1, 1, 0);
    add(0, 0, 0, 1, 6, 1, 0, 0, 0);
    #1;
    chk("rst_out", out, 0);
    chk("rst_ready", load_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_low", low, 0);
    chk("rst_expired", expired, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    foreach (tbl[i]) begin
      @(negedge clk);
      load_valid = tbl[i].lv; load_val = tbl[i].val; pause = tbl[i].p; abort = tbl[i].a;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_out", i), out, tbl[i].eo);
      chk($sformatf("v%0d_ready", i), load_ready, tbl[i].er);
      chk($sformatf("v%0d_busy", i), busy, tbl[i].eb);
      chk($sformatf("v%0d_low", i), low, tbl[i].el);
      chk($sformatf("v%0d_expired", i), expired, tbl[i].ee);
    end
    // Asynchronous reset mid-count
    @(negedge clk);
    load_valid = 1; load_val = 20; pause = 0; abort = 0;
    idle_in();
    repeat (5) @(posedge clk);
    #2;
    chk("mid_out_before", out, 15);
    rst_n = 0;
    #1;
    chk("mid_rst_out", out, 0);
    chk("mid_rst_ready", load_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_expired", expired, 0);
    @(negedge clk);
    rst_n = 1;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("post_rst_expired", expired, 0);
      chk("post_rst_ready", load_ready, 1);
    end
`ifdef COUNTDOWN_AUTORELOAD_EN
    @(negedge clk);
    load_valid = 1; load_val = 3;
    idle_in();
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("ar%0d_expired", c), expired, (c % 4) == 3);
      chk($sformatf("ar%0d_out", c), out, (c % 4) == 3 ? 0 : (c % 4) == 0 ? 3 : 3 - (c % 4));
    end
    @(negedge clk);
    abort = 1;
    @(posedge clk);
    #1;
    chk("ar_abort_ready", load_ready, 1);
    chk("ar_abort_busy", busy, 0);
    idle_in();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
